ysyx_24100005_ifu: RTL

Instruction fetch unit sitting directly upstream of the single-cycle core datapath. It owns the fetch PC and issues one instruction read at a time to instruction memory over a valid/ready request and valid response channel. It presents the fetched word with its PC to the decode/execute stage over a valid/ready handshake. It accepts PC redirects from execute (jal/jalr/branch targets) at any time and discards stale fetches.

---
 rtl/ysyx_24100005_ifu.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ysyx_24100005_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100005_ifu
// Purpose  : Instruction fetch unit. Owns the fetch PC, issues one instruction
//            read at a time, and presents the fetched word to decode/execute.
//            Redirects from execute may arrive at any time. A response that
//            belongs to a superseded fetch is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  // Address on the request channel. It differs from fetch_pc only while a
  // request that was redirected before acceptance must stay stable.
  logic [31:0] req_addr_q, req_addr_d;
  logic        kill_q, kill_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_fault_q, out_fault_d;
  logic        enter_req;

  // Next-state logic: per-state transitions, then a common REQ-entry step
  // that diverts misaligned targets straight into FAULT.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    kill_d      = kill_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_fault_d = out_fault_q;
    enter_req   = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
        // The in-flight (or about to be accepted) request is now stale.
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          kill_d     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          if (mem_resp_valid) begin
            kill_d    = 1'b0;
            enter_req = 1'b1;
          end else begin
            kill_d = 1'b1;
          end
        end else if (mem_resp_valid) begin
          if (kill_q) begin
            kill_d    = 1'b0;
            enter_req = 1'b1;
          end else begin
            out_inst_d  = mem_resp_err ? 32'h0 : mem_resp_data;
            out_fault_d = mem_resp_err;
            out_pc_d    = fetch_pc_q;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD, ST_FAULT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          enter_req  = 1'b1;
        end else if (out_ready) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          enter_req  = 1'b1;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (enter_req) begin
      if (fetch_pc_d[1:0] != 2'b00) begin
        state_d     = ST_FAULT;
        out_pc_d    = fetch_pc_d;
        out_inst_d  = 32'h0;
        out_fault_d = 1'b1;
      end else begin
        state_d    = ST_REQ;
        req_addr_d = fetch_pc_d;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      kill_q      <= 1'b0;
      out_pc_q    <= RESET_PC;
      out_inst_q  <= 32'h0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      kill_q      <= kill_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_fault_q <= out_fault_d;
    end
  end

  // Outputs; handshakes and presented data are forced idle while in reset.
  always_comb begin
    mem_req_valid = ~rst & (state_q == ST_REQ);
    mem_req_addr  = req_addr_q;
    out_valid     = ~rst & ((state_q == ST_HOLD) | (state_q == ST_FAULT));
    out_pc        = rst ? RESET_PC : out_pc_q;
    out_inst      = rst ? 32'h0 : out_inst_q;
    out_fault     = ~rst & out_fault_q;
  end

endmodule
`default_nettype wire
